// File: rtl/pc_ras_pkg.sv
// pc_ras_pkg: shared types for the PC sequencer.
//   pc_src_e   - selects where next_pc comes from
//   next_src() - priority decode: rst > stop > ret > call > branch > increment
package pc_ras_pkg;

  typedef enum logic [2:0] {
    SRC_RST,
    SRC_HOLD,
    SRC_RET,
    SRC_CALL,
    SRC_BR,
    SRC_INC
  } pc_src_e;

  function automatic pc_src_e next_src(input logic rst, input logic stop_en,
                                       input logic ret_en, input logic call_en,
                                       input logic branch_en);
    if (rst)            return SRC_RST;
    else if (stop_en)   return SRC_HOLD;
    else if (ret_en)    return SRC_RET;
    else if (call_en)   return SRC_CALL;
    else if (branch_en) return SRC_BR;
    else                return SRC_INC;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, rst  clock, synchronous active-high reset
//   push      write din at wp, advance wp; overwrites the oldest entry when full
//   pop       remove top entry; popping while empty only sets unf
//   din       return address to push
//   dout      current top entry (mem[wp-1]); meaningless while cnt == 0
//   cnt       valid entries, 0..DEPTH
//   ovf, unf  sticky overflow / underflow, cleared only by rst
// push and pop are never asserted together by the sequencer; push wins if they are.
module ras_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     ovf,
  output logic                     unf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] WP_ONE   = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] wp_top;

  // DEPTH is a power of two, so the pointer wraps on its own.
  assign wp_top = wp - WP_ONE;
  assign dout   = mem[wp_top];

  // Storage is deliberately not reset; cnt gates its visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (push) begin
      wp <= wp + WP_ONE;
      if (cnt == CNT_FULL) ovf <= 1'b1;
      else                 cnt <= cnt + CNT_ONE;
    end else if (pop) begin
      if (cnt == '0) begin
        unf <= 1'b1;
      end else begin
        wp  <= wp_top;
        cnt <= cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pc_ras_seq.sv
// pc_ras_seq: program-counter sequencer with return-address stack.
//   clk, rst      clock, synchronous active-high reset
//   stop_en       hold pc, no stack activity
//   branch_en     jump to branch_pc
//   call_en       jump to branch_pc, push pc+STEP
//   ret_en        jump to popped stack top (pc+STEP when the stack is empty)
//   branch_pc     branch / call target
//   pc            registered current pc
//   next_pc       combinational value loaded into pc at the next edge
//   ras_cnt       valid stack entries
//   ras_ovf/unf   sticky stack overflow / underflow
// STEP and RESET_PC are truncated to PC_W bits (PC_W <= 32).
module pc_ras_seq
  import pc_ras_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int STEP      = 1,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stop_en,
  input  logic                          branch_en,
  input  logic                          call_en,
  input  logic                          ret_en,
  input  logic [PC_W-1:0]               branch_pc,
  output logic [PC_W-1:0]               pc,
  output logic [PC_W-1:0]               next_pc,
  output logic [$clog2(RAS_DEPTH):0]    ras_cnt,
  output logic                          ras_ovf,
  output logic                          ras_unf
);
  localparam logic [PC_W-1:0] STEP_V  = STEP[PC_W-1:0];
  localparam logic [PC_W-1:0] RESET_V = RESET_PC[PC_W-1:0];

  pc_src_e         src;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;

  assign src      = next_src(rst, stop_en, ret_en, call_en, branch_en);
  assign pc_inc   = pc + STEP_V;
  // Only the winning source touches the stack, so a call that loses to
  // ret or stop never pushes.
  assign ras_push = (src == SRC_CALL);
  assign ras_pop  = (src == SRC_RET);

  always_comb begin
    next_pc = pc_inc;
    case (src)
      SRC_RST:  next_pc = RESET_V;
      SRC_HOLD: next_pc = pc;
      // Return on an empty stack falls through to sequential fetch.
      SRC_RET:  next_pc = (ras_cnt == '0) ? pc_inc : ras_top;
      SRC_CALL: next_pc = branch_pc;
      SRC_BR:   next_pc = branch_pc;
      default:  next_pc = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_V;
    else     pc <= next_pc;
  end

  ras_stack #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk  (clk),
    .rst  (rst),
    .push (ras_push),
    .pop  (ras_pop),
    .din  (pc_inc),
    .dout (ras_top),
    .cnt  (ras_cnt),
    .ovf  (ras_ovf),
    .unf  (ras_unf)
  );

endmodule

// File: tb/tb_pc_ras_seq.sv
// Directed bench for pc_ras_seq: a default instance (8-bit, step 1) driven
// through the call/return scenarios, and a 12-bit step-4 instance run
// alongside for the parameter variant. A reference model (queue-based stack)
// predicts each cycle; predictions go into a scoreboard queue and are popped
// after the clock edge.
module tb_pc_ras_seq;

  logic        clk = 1'b0;
  logic        rst, stop_en, branch_en, call_en, ret_en;
  logic [7:0]  branch_pc;
  logic [7:0]  pc, next_pc;
  logic [2:0]  ras_cnt;
  logic        ras_ovf, ras_unf;

  logic        v_zero = 1'b0;
  logic [11:0] v_bpc  = '0;
  logic [11:0] v_pc, v_next_pc;
  logic [2:0]  v_ras_cnt;
  logic        v_ovf, v_unf;

  always #5 clk = ~clk;

  pc_ras_seq #(.PC_W(8), .STEP(1), .RESET_PC(0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stop_en(stop_en), .branch_en(branch_en),
    .call_en(call_en), .ret_en(ret_en), .branch_pc(branch_pc),
    .pc(pc), .next_pc(next_pc), .ras_cnt(ras_cnt),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  pc_ras_seq #(.PC_W(12), .STEP(4), .RESET_PC(12'h100), .RAS_DEPTH(4)) dut_v (
    .clk(clk), .rst(rst), .stop_en(v_zero), .branch_en(v_zero),
    .call_en(v_zero), .ret_en(v_zero), .branch_pc(v_bpc),
    .pc(v_pc), .next_pc(v_next_pc), .ras_cnt(v_ras_cnt),
    .ras_ovf(v_ovf), .ras_unf(v_unf)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
    logic [11:0] vpc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_stk[$];
  logic [7:0] m_pc;
  logic [11:0] m_vpc;
  logic       m_ovf, m_unf;
  logic       wrap_seen = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, predict, check next_pc, enqueue, clock, dequeue, check.
  task automatic step(input logic r, input logic s, input logic b,
                      input logic c, input logic t, input logic [7:0] bp);
    logic [7:0]  np;
    logic [11:0] vnp;
    exp_t        e, got;
    rst = r; stop_en = s; branch_en = b; call_en = c; ret_en = t; branch_pc = bp;
    #1;
    if (r) begin
      np = 8'h00; vnp = 12'h100;
      m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      vnp = m_vpc + 12'd4;
      if (m_vpc == 12'hFFC && vnp == 12'h000) wrap_seen = 1'b1;
      if (s) np = m_pc;
      else if (t) begin
        if (m_stk.size() > 0) np = m_stk.pop_back();
        else begin np = m_pc + 8'd1; m_unf = 1'b1; end
      end else if (c) begin
        m_stk.push_back(m_pc + 8'd1);
        if (m_stk.size() > 4) begin void'(m_stk.pop_front()); m_ovf = 1'b1; end
        np = bp;
      end else if (b) np = bp;
      else np = m_pc + 8'd1;
    end
    chk("next_pc", {24'd0, next_pc}, {24'd0, np});
    chk("v_next_pc", {20'd0, v_next_pc}, {20'd0, vnp});
    m_pc = np; m_vpc = vnp;
    e.pc = np; e.cnt = 3'(m_stk.size()); e.ovf = m_ovf; e.unf = m_unf; e.vpc = vnp;
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    chk("pc", {24'd0, pc}, {24'd0, got.pc});
    chk("ras_cnt", {29'd0, ras_cnt}, {29'd0, got.cnt});
    chk("ras_ovf", {31'd0, ras_ovf}, {31'd0, got.ovf});
    chk("ras_unf", {31'd0, ras_unf}, {31'd0, got.unf});
    chk("v_pc", {20'd0, v_pc}, {20'd0, got.vpc});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; stop_en = 1'b0; branch_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
    branch_pc = '0;
    @(posedge clk); #1;

    // Reset, then free-run through an 8-bit wrap.
    step(1, 0, 0, 0, 0, 8'h00);
    chk("reset_pc", {24'd0, pc}, 32'h0);
    chk("reset_vpc", {20'd0, v_pc}, 32'h100);
    idle(300);
    chk("idle_wrap_pc", {24'd0, pc}, 32'h2C);
    chk("idle_cnt", {29'd0, ras_cnt}, 32'h0);

    // Single call / return.
    step(1, 0, 0, 0, 0, 8'h00);
    idle(16);
    chk("pre_call_pc", {24'd0, pc}, 32'h10);
    step(0, 0, 1, 1, 0, 8'h80);
    chk("call_pc", {24'd0, pc}, 32'h80);
    chk("call_cnt", {29'd0, ras_cnt}, 32'h1);
    idle(3);
    step(0, 0, 0, 0, 1, 8'h00);
    chk("ret_pc", {24'd0, pc}, 32'h11);
    chk("ret_cnt", {29'd0, ras_cnt}, 32'h0);

    // Plain branch.
    step(0, 0, 1, 0, 0, 8'hF0);
    chk("branch_pc", {24'd0, pc}, 32'hF0);

    // Five nested calls overflow a 4-deep stack.
    step(1, 0, 0, 0, 0, 8'h00);
    idle(1);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 0, 8'(i + 1));
    step(0, 0, 0, 1, 0, 8'h20);
    chk("nest_cnt", {29'd0, ras_cnt}, 32'h4);
    chk("nest_ovf", {31'd0, ras_ovf}, 32'h1);
    step(0, 0, 0, 0, 1, 8'h00); chk("ret1", {24'd0, pc}, 32'h06);
    step(0, 0, 0, 0, 1, 8'h00); chk("ret2", {24'd0, pc}, 32'h05);
    step(0, 0, 0, 0, 1, 8'h00); chk("ret3", {24'd0, pc}, 32'h04);
    step(0, 0, 0, 0, 1, 8'h00); chk("ret4", {24'd0, pc}, 32'h03);
    step(0, 0, 0, 0, 1, 8'h00);
    chk("ret5_pc", {24'd0, pc}, 32'h04);
    chk("ret5_unf", {31'd0, ras_unf}, 32'h1);
    idle(2);
    chk("unf_sticky", {31'd0, ras_unf}, 32'h1);

    // stop_en overrides everything; call+ret together pops without pushing.
    step(1, 0, 0, 0, 0, 8'h00);
    idle(5);
    step(0, 0, 0, 1, 0, 8'h40);
    step(0, 1, 1, 1, 1, 8'h77);
    chk("stop_pc", {24'd0, pc}, 32'h40);
    chk("stop_cnt", {29'd0, ras_cnt}, 32'h1);
    step(0, 0, 0, 1, 1, 8'h77);
    chk("callret_pc", {24'd0, pc}, 32'h06);
    chk("callret_cnt", {29'd0, ras_cnt}, 32'h0);

    // Reset in the middle of a call sequence with overflow set.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 8'(8'h30 + i));
    step(0, 0, 0, 0, 1, 8'h00);
    chk("mid_cnt", {29'd0, ras_cnt}, 32'h3);
    chk("mid_ovf", {31'd0, ras_ovf}, 32'h1);
    step(1, 0, 0, 0, 0, 8'h00);
    chk("mid_rst_pc", {24'd0, pc}, 32'h0);
    chk("mid_rst_cnt", {29'd0, ras_cnt}, 32'h0);
    chk("mid_rst_ovf", {31'd0, ras_ovf}, 32'h0);

    // Long run for the 12-bit variant to wrap 0xFFC -> 0x000.
    idle(1000);
    chk("v_wrap_seen", {31'd0, wrap_seen}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
